// File: rtl/sppf_concat_stream_if.sv
// Frame-in / element-stream-out bundle for sppf_concat_stream.
// frame_cnt exists only when SPPF_CONCAT_FRAME_CNT_EN is defined.
interface sppf_concat_stream_if #(
  parameter int DATA_WIDTH = 16,
  parameter int K          = 1,
  parameter int H          = 1,
  parameter int W          = 1
);
  localparam int BUS_W = K * H * W * DATA_WIDTH;
  localparam int CH_W  = ($clog2(4 * K) < 1) ? 1 : $clog2(4 * K);

  logic                          in_valid;
  logic                          in_ready;
  logic        [BUS_W-1:0]       x_in;
  logic        [BUS_W-1:0]       m5_in;
  logic        [BUS_W-1:0]       m9_in;
  logic        [BUS_W-1:0]       m13_in;
  logic signed [DATA_WIDTH-1:0]  out_data;
  logic                          out_valid;
  logic                          out_ready;
  logic                          out_last;
  logic        [CH_W-1:0]        out_chan;
`ifdef SPPF_CONCAT_FRAME_CNT_EN
  logic        [15:0]            frame_cnt;
`endif

  // master: the concat block (captures frames, drives the stream)
  modport master (
    input  in_valid, x_in, m5_in, m9_in, m13_in, out_ready,
`ifdef SPPF_CONCAT_FRAME_CNT_EN
    output frame_cnt,
`endif
    output in_ready, out_data, out_valid, out_last, out_chan
  );

  // slave: the surrounding pool stage and 1x1 conv consumer
  modport slave (
    output in_valid, x_in, m5_in, m9_in, m13_in, out_ready,
`ifdef SPPF_CONCAT_FRAME_CNT_EN
    input  frame_cnt,
`endif
    input  in_ready, out_data, out_valid, out_last, out_chan
  );
endinterface

// File: rtl/sppf_concat_stream.sv
// Captures x/m5/m9/m13 maps and streams them pixel-major as [x,m5,m9,m13] x K channels.
// Optional completed-frame counter enabled by SPPF_CONCAT_FRAME_CNT_EN.
module sppf_concat_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int K          = 1,
  parameter int H          = 1,
  parameter int W          = 1
) (
  input logic                  clk,
  input logic                  reset,
  sppf_concat_stream_if.master bus
);
  localparam int HW    = H * W;
  localparam int BUS_W = K * HW * DATA_WIDTH;
  localparam int P_W   = (HW > 1) ? $clog2(HW) : 1;
  localparam int C_W   = (K > 1) ? $clog2(K) : 1;
  localparam int CH_W  = ($clog2(4 * K) < 1) ? 1 : $clog2(4 * K);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                       state;
  logic [3:0][BUS_W-1:0]        frame_p0;
  logic [P_W-1:0]               pix;
  logic [1:0]                   grp;
  logic [C_W-1:0]               chn;
  logic                         rdy_p1;
  logic                         vld_p1;
  logic                         last_p1;
  logic signed [DATA_WIDTH-1:0] data_p1;
  logic [CH_W-1:0]              chan_p1;
`ifdef SPPF_CONCAT_FRAME_CNT_EN
  logic [15:0]                  frame_cnt;
`endif

  logic                         c_wrap;
  logic                         g_wrap;
  logic [P_W-1:0]               nxt_p;
  logic [1:0]                   nxt_g;
  logic [C_W-1:0]               nxt_c;
  logic                         nxt_last;
  logic [CH_W-1:0]              nxt_chan;
  logic signed [DATA_WIDTH-1:0] nxt_data;

  // Element (c,h,w) sits at flat index (c*H+h)*W+w, which equals c*H*W + p.
  function automatic logic signed [DATA_WIDTH-1:0] elem_sel(
    input logic [BUS_W-1:0] map,
    input logic [P_W-1:0]   p,
    input logic [C_W-1:0]   c
  );
    logic [BUS_W-1:0] shifted;
    int               idx;
    idx     = int'(c) * HW + int'(p);
    shifted = map >> (idx * DATA_WIDTH);
    return shifted[DATA_WIDTH-1:0];
  endfunction

  always_comb begin
    c_wrap   = (chn == C_W'(K - 1));
    g_wrap   = (grp == 2'd3);
    nxt_c    = c_wrap ? '0 : chn + C_W'(1);
    nxt_g    = c_wrap ? grp + 2'd1 : grp;
    nxt_p    = (c_wrap && g_wrap) ? pix + P_W'(1) : pix;
    nxt_last = (nxt_c == C_W'(K - 1)) && (nxt_g == 2'd3) && (nxt_p == P_W'(HW - 1));
    nxt_chan = CH_W'(int'(nxt_g) * K + int'(nxt_c));
    nxt_data = elem_sel(frame_p0[nxt_g], nxt_p, nxt_c);
  end

  // ---- capture stage: frame buffer, loaded only on an accepted frame ----
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.in_valid)
      frame_p0 <= {bus.m13_in, bus.m9_in, bus.m5_in, bus.x_in};
  end

  // ---- stream stage: FSM, counters and registered stream outputs ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rdy_p1    <= 1'b1;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
      data_p1   <= '0;
      chan_p1   <= '0;
      pix       <= '0;
      grp       <= '0;
      chn       <= '0;
`ifdef SPPF_CONCAT_FRAME_CNT_EN
      frame_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            state   <= STREAM;
            rdy_p1  <= 1'b0;
            vld_p1  <= 1'b1;
            // First element comes straight off the bus; the buffer loads this same edge.
            data_p1 <= bus.x_in[DATA_WIDTH-1:0];
            chan_p1 <= '0;
            last_p1 <= 1'b0;
            pix     <= '0;
            grp     <= '0;
            chn     <= '0;
          end
        end
        STREAM: begin
          if (bus.out_ready) begin
            if (last_p1) begin
              state     <= IDLE;
              rdy_p1    <= 1'b1;
              vld_p1    <= 1'b0;
              last_p1   <= 1'b0;
              pix       <= '0;
              grp       <= '0;
              chn       <= '0;
`ifdef SPPF_CONCAT_FRAME_CNT_EN
              frame_cnt <= frame_cnt + 16'd1;
`endif
            end else begin
              pix     <= nxt_p;
              grp     <= nxt_g;
              chn     <= nxt_c;
              data_p1 <= nxt_data;
              chan_p1 <= nxt_chan;
              last_p1 <= nxt_last;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = rdy_p1;
  assign bus.out_valid = vld_p1;
  assign bus.out_last  = last_p1;
  assign bus.out_data  = data_p1;
  assign bus.out_chan  = chan_p1;
`ifdef SPPF_CONCAT_FRAME_CNT_EN
  assign bus.frame_cnt = frame_cnt;
`endif
endmodule

// File: doc/sppf_concat_stream.md
Name: sppf_concat_stream

Overview:
- Downstream neighbour of the SPPF padding/max-pool stage.
- Captures the pass-through feature map x and the three pooled maps (m5, m9, m13) as flat buses.
- Emits them as one channel-concatenated element stream with valid/ready handshake, in SPPF order [x, m5, m9, m13] per pixel.
- Feeds the following 1x1 convolution stage, pixel-major.

Parameters:
- DATA_WIDTH, 16, element width (two's-complement fixed point, passed unchanged).
- K, 1, channels per input map; output carries 4*K channels.
- H, 1, feature-map height.
- W, 1, feature-map width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  all four input buses are valid.
- in_ready  output  1  block can capture a frame.
- x_in  input  K*H*W*DATA_WIDTH  un-pooled map.
- m5_in  input  K*H*W*DATA_WIDTH  5x5 max-pool result.
- m9_in  input  K*H*W*DATA_WIDTH  9x9 max-pool result.
- m13_in  input  K*H*W*DATA_WIDTH  13x13 max-pool result.
- out_data  output  DATA_WIDTH  current stream element.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts element.
- out_last  output  1  final element of frame.
- out_chan  output  clog2(4*K) (min 1)  concatenated channel index of out_data.

Behaviour:
- Flat bus layout: element (k,h,w) at bits [((k*H+h)*W+w)*DATA_WIDTH +: DATA_WIDTH].
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid, register all four buses into a frame buffer, clear counters, go to STREAM.
  - STREAM: in_ready=0, out_valid=1.
  - DONE is transient: after the last handshake, return to IDLE the next cycle.
- Counters: pixel p (0..H*W-1, row-major h then w), group g (0..3 = x, m5, m9, m13), channel c (0..K-1).
  - Emission order: for each p, for g = 0..3, for c = 0..K-1.
- out_data = buffer[g] element (c, p/W, p%W). out_chan = g*K+c.
- Counters advance only on out_valid && out_ready.
  - c wraps to 0 and increments g; g wraps from 3 to 0 and increments p.
- out_last = 1 while p=H*W-1, g=3, c=K-1. The handshake on that element ends the frame.
- Frame length is exactly 4*K*H*W elements.
- Latency:
  - First out_valid is the cycle after capture.
  - With out_ready held high: one element per cycle.
  - in_ready rises again one cycle after the last handshake.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_chan and out_last hold stable.
- Input bus changes after capture have no effect until the next capture.
- in_valid while in_ready=0 is ignored; the upstream stage holds its data.
- Reset (any state, including mid-frame):
  - next cycle: state IDLE, in_ready=1, out_valid=0, out_last=0, out_data=0, out_chan=0;
  - counters 0; the partially streamed frame is discarded.
- No arithmetic: values are copied bit-exact, including negative values.

Optional Feature:
- Macro SPPF_CONCAT_FRAME_CNT_EN.
- Defined:
  - Adds output frame_cnt (16 bits): counts completed frames, i.e. handshakes with out_last=1.
  - Wraps 16'hFFFF -> 0. Cleared by reset.
  - Lets the bench and ILA check frame throughput.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- K=H=W=1; x_in=16'hF0FF, m5_in=16'h0D3D, m9_in=16'h1234, m13_in=16'h8001; in_valid pulse; out_ready=1 -> out_data F0FF, 0D3D, 1234, 8001 on 4 consecutive cycles; out_chan 0,1,2,3; out_last only on 8001; in_ready=1 the cycle after.
- K=2, H=W=2, element value = {g[1:0], k[0], h[0], w[0]} pattern -> 32 elements in pixel-major order [x c0,c1, m5 c0,c1, ...]; out_chan cycles 0..7 four times.
- Same frame with out_ready toggled 1,0,0,1,... -> no element dropped or duplicated; outputs held while out_ready=0.
- Reset asserted after the 2nd handshake of a K=1 frame -> out_valid=0, in_ready=1 next cycle; a new frame then streams from out_chan 0.
- in_valid held high with changing buses during STREAM -> stream reflects only the captured frame; second capture occurs only after out_last handshake.
- With SPPF_CONCAT_FRAME_CNT_EN: 3 back-to-back frames -> frame_cnt = 1, 2, 3 after each last handshake; reset -> 0.
